// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller:
// FSM states, the multiply/divide counter width and the default latencies.
package pipe_hazard_ctrl_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_e;

    localparam int MD_CNT_W       = 6;
    localparam int MUL_CYCLES_DEF = 4;
    localparam int DIV_CYCLES_DEF = 32;

endpackage

// File: rtl/md_busy_timer.sv
// Down-counter tracking how long HI/LO stay invalid after a MULT/DIV issue.
// A load restarts the count; done fires in the last busy cycle unless a load aborts it.
module md_busy_timer
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                load_i,
    input  logic [MD_CNT_W-1:0] load_val_i,
    input  logic                dec_i,
    output logic                busy_o,
    output logic                done_o
);

    logic [MD_CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign busy_o = (cnt_q != '0);
    // Restart on the final cycle swallows the pulse of the aborted operation.
    assign done_o = dec_i & ~load_i & (cnt_q == MD_CNT_W'(1));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline stall/flush controller: memory wait, load-use, HI/LO interlock and
// taken-branch flush, resolved by fixed priority into register enables and bubble clears.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int MUL_CYCLES = MUL_CYCLES_DEF,
    parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rt,
    input  logic       id_mfhilo,
    input  logic       br_taken_id,
    input  logic       ex_memread,
    input  logic [4:0] ex_wa,
    input  logic       ex_md_start,
    input  logic       ex_md_div,
    input  logic       mem_req,
    input  logic       dmem_ready,
    output logic       pc_en,
    output logic       ifid_en,
    output logic       idex_en,
    output logic       exmem_en,
    output logic       memwb_en,
    output logic       ifid_clr,
    output logic       idex_clr,
    output logic       md_busy,
    output logic       md_done
);

    localparam logic [MD_CNT_W-1:0] MUL_LOAD = MD_CNT_W'(MUL_CYCLES - 1);
    localparam logic [MD_CNT_W-1:0] DIV_LOAD = MD_CNT_W'(DIV_CYCLES - 1);

    state_e state_q, state_d;
    logic   load_use;
    logic   md_hazard;
    logic   mem_stall;
    logic   hold_all;
    logic   md_load;

    assign load_use  = ex_memread & (ex_wa != 5'd0) &
                       ((ex_wa == id_rs) | (id_uses_rt & (ex_wa == id_rt)));
    assign md_hazard = id_mfhilo & md_busy;
    assign mem_stall = mem_req & ~dmem_ready;
    // Once waiting, the freeze holds on dmem_ready alone, independent of mem_req.
    assign hold_all  = (state_q == MEM_WAIT) ? ~dmem_ready : mem_stall;

    always_comb begin
        state_d  = state_q;
        pc_en    = 1'b1;
        ifid_en  = 1'b1;
        idex_en  = 1'b1;
        exmem_en = 1'b1;
        memwb_en = 1'b1;
        ifid_clr = 1'b0;
        idex_clr = 1'b0;

        unique case (state_q)
            RUN:      if (mem_stall)  state_d = MEM_WAIT;
            MEM_WAIT: if (dmem_ready) state_d = RUN;
            default:  state_d = RUN;
        endcase

        if (rst) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
            memwb_en = 1'b0;
        end else if (hold_all) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
            memwb_en = 1'b0;
        end else if (load_use || md_hazard) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_clr = 1'b1;
        end else if (br_taken_id) begin
            ifid_clr = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // A start frozen in EX by a memory stall is re-issued when EX advances.
    assign md_load = ex_md_start & exmem_en;

    md_busy_timer u_md_busy_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (md_load),
        .load_val_i (ex_md_div ? DIV_LOAD : MUL_LOAD),
        .dec_i      (1'b1),
        .busy_o     (md_busy),
        .done_o     (md_done)
    );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed hazard scenarios followed by
// randomized traffic, all compared against a rule-level reference model.
module tb_pipe_hazard_ctrl;

    localparam int MUL_C = 4;
    localparam int DIV_C = 32;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs, id_rt, ex_wa;
    logic       id_uses_rt, id_mfhilo, br_taken_id, ex_memread;
    logic       ex_md_start, ex_md_div, mem_req, dmem_ready;
    logic       pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic       ifid_clr, idex_clr, md_busy, md_done;

    int checks = 0;
    int errors = 0;

    // Reference model state: remaining busy cycles and whether a memory wait is pending.
    int m_cnt;
    bit m_wait;
    logic [8:0] obs;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.MUL_CYCLES(MUL_C), .DIV_CYCLES(DIV_C)) dut (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt), .id_mfhilo(id_mfhilo),
        .br_taken_id(br_taken_id), .ex_memread(ex_memread), .ex_wa(ex_wa),
        .ex_md_start(ex_md_start), .ex_md_div(ex_md_div),
        .mem_req(mem_req), .dmem_ready(dmem_ready),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
        .memwb_en(memwb_en), .ifid_clr(ifid_clr), .idex_clr(idex_clr),
        .md_busy(md_busy), .md_done(md_done)
    );

    wire [8:0] dut_vec = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                          ifid_clr, idex_clr, md_busy, md_done};

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Expected {pc,ifid,idex,exmem,memwb,ifid_clr,idex_clr,busy,done} from the rules.
    function automatic logic [8:0] model_out();
        bit   busy, lu, mh, ms, ld;
        logic [4:0] en;
        bit   fclr, bclr, done;
        if (rst) return 9'd0;
        busy = (m_cnt > 0);
        ms   = m_wait ? !dmem_ready : (mem_req && !dmem_ready);
        lu   = ex_memread && ex_wa != 0 &&
               (ex_wa == id_rs || (id_uses_rt && ex_wa == id_rt));
        mh   = id_mfhilo && busy;
        en   = 5'b11111; fclr = 0; bclr = 0;
        if (ms)            en = 5'b00000;
        else if (lu || mh) begin en = 5'b00111; bclr = 1; end
        else if (br_taken_id) fclr = 1;
        ld   = ex_md_start && en[1];
        done = (m_cnt == 1) && !ld;
        return {en, fclr, bclr, busy, done};
    endfunction

    task automatic model_reset();
        m_cnt  = 0;
        m_wait = 0;
    endtask

    task automatic model_edge();
        logic [8:0] e;
        bit ms_raw;
        e = model_out();
        if (rst) begin
            model_reset();
        end else begin
            ms_raw = mem_req && !dmem_ready;
            m_wait = m_wait ? !dmem_ready : ms_raw;
            if (ex_md_start && e[5]) m_cnt = (ex_md_div ? DIV_C : MUL_C) - 1;
            else if (m_cnt > 0)      m_cnt = m_cnt - 1;
        end
    endtask

    // One cycle: inputs already driven after a falling edge; check, clock, re-align.
    task automatic cyc(input string tag);
        #1;
        obs = dut_vec;
        chk(tag, {23'd0, obs}, {23'd0, model_out()});
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic idle();
        id_rs = 0; id_rt = 0; ex_wa = 0; id_uses_rt = 0; id_mfhilo = 0;
        br_taken_id = 0; ex_memread = 0; ex_md_start = 0; ex_md_div = 0;
        mem_req = 0; dmem_ready = 1;
    endtask

    initial begin
        int nb, ns, nz, donei, ndone;
        idle();
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        cyc("reset0");
        chk("reset_zero", {23'd0, obs}, 32'd0);
        cyc("reset1");
        rst = 1'b0;
        cyc("post_rst");
        chk("post_rst_normal", {25'd0, obs[8:2]}, 32'h7C);

        // Load-use on rs: one stall cycle, then the bubble lets ID advance.
        ex_memread = 1; ex_wa = 5; id_rs = 5;
        cyc("lu");
        chk("lu_stall", {29'd0, obs[8], obs[7], obs[2]}, 32'b001);
        ex_memread = 0;
        cyc("lu_next");
        chk("lu_release", {27'd0, obs[8:4]}, 32'h1F);

        // Loads to $zero never interlock.
        ex_memread = 1; ex_wa = 0; id_rs = 0;
        cyc("zero");
        chk("zero_nostall", {25'd0, obs[8:2]}, 32'h7C);

        // Divide: busy window, completion pulse and MFHI interlock.
        idle();
        ex_md_start = 1; ex_md_div = 1;
        cyc("div_start");
        ex_md_start = 0;
        nb = 0; ns = 0; donei = -1;
        for (int i = 1; i <= 40; i++) begin
            if (i == 2) id_mfhilo = 1;
            cyc("div_run");
            nb += obs[1];
            if (obs[0]) donei = i;
            if (!obs[8]) ns++;
        end
        chk("div_busy_cycles", nb, 31);
        chk("div_done_cycle", donei, 31);
        chk("div_mfhi_stalls", ns, 30);

        // Memory wait with a multiply counting underneath.
        idle();
        ex_md_start = 1;
        cyc("mul_start");
        ex_md_start = 0; mem_req = 1; dmem_ready = 0;
        nz = 0; donei = -1;
        for (int i = 1; i <= 3; i++) begin
            cyc("mw");
            if (obs[8:4] == 5'd0) nz++;
            if (obs[0]) donei = i;
        end
        dmem_ready = 1;
        cyc("mw_release");
        chk("mw_freeze_cycles", nz, 3);
        chk("mw_mul_done", donei, 3);
        chk("mw_release_en", {27'd0, obs[8:4]}, 32'h1F);

        // Branch under load-use is held off, then flushes on retry.
        idle();
        ex_memread = 1; ex_wa = 7; id_rt = 7; id_uses_rt = 1; br_taken_id = 1;
        cyc("br_lu");
        chk("br_suppressed", {30'd0, obs[3], obs[2]}, 32'b01);
        ex_memread = 0;
        cyc("br_retry");
        chk("br_flush", {31'd0, obs[3]}, 32'd1);

        // Reset while waiting on memory with a divide mid-flight.
        idle();
        ex_md_start = 1; ex_md_div = 1;
        cyc("rd_start");
        ex_md_start = 0;
        for (int i = 1; i <= 20; i++) cyc("rd_run");
        mem_req = 1; dmem_ready = 0;
        cyc("rd_enter_wait");
        chk("rd_cnt10", m_cnt, 10);
        rst = 1'b1;
        model_reset();
        #1;
        chk("rst_async", {23'd0, dut_vec}, 32'd0);
        cyc("rst_hold");
        rst = 1'b0;
        idle();
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            cyc("rst_after");
            ndone += obs[0];
        end
        chk("rst_no_done", ndone, 0);

        // Randomized traffic with small register numbers to provoke collisions.
        for (int i = 0; i < 3000; i++) begin
            id_rs       = 5'($urandom_range(0, 3));
            id_rt       = 5'($urandom_range(0, 3));
            ex_wa       = 5'($urandom_range(0, 3));
            id_uses_rt  = 1'($urandom_range(0, 1));
            id_mfhilo   = ($urandom_range(0, 3) == 0);
            br_taken_id = ($urandom_range(0, 3) == 0);
            ex_memread  = ($urandom_range(0, 2) == 0);
            ex_md_start = ($urandom_range(0, 15) == 0);
            ex_md_div   = 1'($urandom_range(0, 1));
            mem_req     = ($urandom_range(0, 2) == 0);
            dmem_ready  = ($urandom_range(0, 4) < 3);
            if ($urandom_range(0, 99) == 0) begin
                rst = 1'b1;
                model_reset();
            end else begin
                rst = 1'b0;
            end
            cyc("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
